spi_master_ss: RTL and testbench

Parametrised SPI master, successor to the fixed 10-slave-select flash SPI port. It runs single-word full-duplex transfers with runtime-selectable CPOL/CPHA and bit order, and drives one of `NUM_SS` active-low slave selects. It sits between the on-chip processor's register interface and the board SPI pins, and replaces the fixed-function SPI instance.

---
 rtl/spi_master_ss.sv | 165 ++++++++++++++++
 tb/tb_spi_master_ss.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ss.sv
// Single-word full-duplex SPI master with runtime CPOL/CPHA/bit order and NUM_SS active-low selects.
// Optional macro SPI_LOOPBACK_EN adds loopback_i, which feeds the MOSI register into the receiver.
module spi_master_ss #(
    parameter int unsigned  NUM_SS  = 10,
    parameter int unsigned  DATA_W  = 8,
    parameter int unsigned  CLK_DIV = 4,
    localparam int unsigned SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              USER_CLOCK,
    input  logic              EXT_RESET_N,
    input  logic              start_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic [SS_W-1:0]   ss_sel_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_first_i,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic [NUM_SS-1:0] SPI_FLASH_SS,
    output logic              SPI_FLASH_MOSI,
    output logic              SPI_FLASH_SCLK,
    input  logic              SPI_FLASH_MISO
);
    localparam int unsigned     PH_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned     ED_W      = $clog2(2 * DATA_W);
    localparam int unsigned     SSC_W     = SS_W + 1;
    localparam logic [PH_W-1:0] PhaseLast = PH_W'(CLK_DIV - 1);
    localparam logic [ED_W-1:0] EdgeLast  = ED_W'(2 * DATA_W - 1);
    localparam logic [SSC_W-1:0] NumSs    = SSC_W'(NUM_SS);

    typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     phase_q;
    logic [ED_W-1:0]     edge_q;
    logic                sclk_q, mosi_q, cpha_q, lsb_q, done_q, err_q;
    logic [NUM_SS-1:0]   ss_q;
    logic [DATA_W-1:0]   tx_q, rx_sh_q, rx_q;

    logic phase_end, sel_ok, accept, reject, xfer_tick;
    logic leading, do_sample, do_shift, rx_bit;
    logic [DATA_W-1:0] tx_next, rx_next;
    logic tx_next_bit;

    always_comb begin
        state_d   = state_q;
        phase_end = (phase_q == PhaseLast);
        sel_ok    = ({1'b0, ss_sel_i} < NumSs);
        accept    = 1'b0;
        reject    = 1'b0;
        xfer_tick = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (sel_ok) begin
                        accept  = 1'b1;
                        state_d = StSetup;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            StSetup: if (phase_end) state_d = StXfer;
            StXfer: begin
                if (phase_end) begin
                    xfer_tick = 1'b1;
                    if (edge_q == EdgeLast) state_d = StHold;
                end
            end
            StHold:  if (phase_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Even edge count means the upcoming toggle is a leading edge.
    assign leading   = ~edge_q[0];
    assign do_sample = xfer_tick & (leading ^ cpha_q);
    assign do_shift  = xfer_tick & (cpha_q ? (leading & (edge_q != '0))
                                           : (~leading & (edge_q != EdgeLast)));

`ifdef SPI_LOOPBACK_EN
    assign rx_bit = loopback_i ? mosi_q : SPI_FLASH_MISO;
`else
    assign rx_bit = SPI_FLASH_MISO;
`endif

    always_comb begin
        tx_next     = lsb_q ? (tx_q >> 1) : (tx_q << 1);
        tx_next_bit = lsb_q ? tx_q[1] : tx_q[DATA_W-2];
        rx_next     = lsb_q ? {rx_bit, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], rx_bit};
    end

    always_ff @(posedge USER_CLOCK or negedge EXT_RESET_N) begin
        if (!EXT_RESET_N) state_q <= StIdle;
        else              state_q <= state_d;
    end

    always_ff @(posedge USER_CLOCK or negedge EXT_RESET_N) begin
        if (!EXT_RESET_N) begin
            phase_q <= '0;
            edge_q  <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ss_q    <= '1;
            tx_q    <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= reject;
            if (state_q == StIdle || phase_end) phase_q <= '0;
            else                                phase_q <= phase_q + PH_W'(1);
            unique case (state_q)
                StIdle: begin
                    sclk_q <= cpol_i;
                    if (accept) begin
                        tx_q   <= tx_data_i;
                        mosi_q <= lsb_first_i ? tx_data_i[0] : tx_data_i[DATA_W-1];
                        ss_q   <= ~(NUM_SS'(1) << ss_sel_i);
                        cpha_q <= cpha_i;
                        lsb_q  <= lsb_first_i;
                    end
                end
                StSetup: if (phase_end) edge_q <= '0;
                StXfer: begin
                    if (phase_end) begin
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + ED_W'(1);
                    end
                end
                StHold: begin
                    if (phase_end) begin
                        ss_q   <= '1;
                        rx_q   <= rx_sh_q;
                        done_q <= 1'b1;
                    end
                end
                default: ss_q <= '1;
            endcase
            if (do_sample) rx_sh_q <= rx_next;
            if (do_shift) begin
                tx_q   <= tx_next;
                mosi_q <= tx_next_bit;
            end
        end
    end

    assign busy_o         = (state_q != StIdle);
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign rx_data_o      = rx_q;
    assign SPI_FLASH_SS   = ss_q;
    assign SPI_FLASH_MOSI = mosi_q;
    assign SPI_FLASH_SCLK = sclk_q;

endmodule

// File: tb/tb_spi_master_ss.sv
// Directed bench for spi_master_ss: default instance with a mode-aware slave model, plus a
// DATA_W=16/CLK_DIV=1 instance for back-to-back timing.
module tb_spi_master_ss;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default instance
    logic       rst0 = 1'b0, start0 = 1'b0, cpol0 = 1'b0, cpha0 = 1'b0, lsb0 = 1'b0;
    logic [7:0] tx0 = '0, rx0;
    logic [3:0] sel0 = '0;
    logic       busy0, done0, err0, mosi0, sclk0, miso0;
    logic [9:0] ss0;
`ifdef SPI_LOOPBACK_EN
    logic       loopback0 = 1'b0;
`endif

    spi_master_ss dut0 (
        .USER_CLOCK     (clk),
        .EXT_RESET_N    (rst0),
        .start_i        (start0),
        .tx_data_i      (tx0),
        .ss_sel_i       (sel0),
        .cpol_i         (cpol0),
        .cpha_i         (cpha0),
        .lsb_first_i    (lsb0),
`ifdef SPI_LOOPBACK_EN
        .loopback_i     (loopback0),
`endif
        .busy_o         (busy0),
        .done_o         (done0),
        .err_o          (err0),
        .rx_data_o      (rx0),
        .SPI_FLASH_SS   (ss0),
        .SPI_FLASH_MOSI (mosi0),
        .SPI_FLASH_SCLK (sclk0),
        .SPI_FLASH_MISO (miso0)
    );

    // Wide/fast instance, MISO tied high
    logic        rst1 = 1'b0, start1 = 1'b0;
    logic [15:0] tx1 = '0, rx1;
    logic [3:0]  sel1 = '0;
    logic        busy1, done1, err1, mosi1, sclk1;
    logic [9:0]  ss1;

    spi_master_ss #(.DATA_W(16), .CLK_DIV(1)) dut1 (
        .USER_CLOCK     (clk),
        .EXT_RESET_N    (rst1),
        .start_i        (start1),
        .tx_data_i      (tx1),
        .ss_sel_i       (sel1),
        .cpol_i         (1'b0),
        .cpha_i         (1'b0),
        .lsb_first_i    (1'b0),
`ifdef SPI_LOOPBACK_EN
        .loopback_i     (1'b0),
`endif
        .busy_o         (busy1),
        .done_o         (done1),
        .err_o          (err1),
        .rx_data_o      (rx1),
        .SPI_FLASH_SS   (ss1),
        .SPI_FLASH_MOSI (mosi1),
        .SPI_FLASH_SCLK (sclk1),
        .SPI_FLASH_MISO (1'b1)
    );

    // Slave model / pin monitor for dut0: counts SCLK toggles while selected,
    // captures MOSI on the slave's sampling edge and drives MISO per CPHA.
    logic [7:0] m_slv = '0;
    logic [7:0] mon_cap = '0;
    int         mon_tog = 0, mon_rise = 0;
    logic       ss_prev_high = 1'b1, sclk_prev = 1'b0;

    always @(sclk0 or ss0) begin
        if (ss0 == 10'h3FF) begin
            ss_prev_high = 1'b1;
        end else if (ss_prev_high) begin
            ss_prev_high = 1'b0;
            mon_tog  = 0;
            mon_rise = 0;
            mon_cap  = '0;
        end else if (sclk0 != sclk_prev) begin
            mon_tog++;
            if (sclk0) mon_rise++;
            if (((mon_tog % 2) == 1) != (cpha0 == 1'b1)) mon_cap = {mon_cap[6:0], mosi0};
        end
        sclk_prev = sclk0;
    end

    always_comb begin
        int k;
        k = cpha0 ? ((mon_tog == 0) ? 0 : (mon_tog - 1) / 2) : mon_tog / 2;
        if (k > 7) k = 7;
        miso0 = lsb0 ? m_slv[k] : m_slv[7 - k];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic string nm(input int id, input string s);
        return $sformatf("v%0d_%s", id, s);
    endfunction

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic       lsb;
        logic [7:0] tx;
        logic [7:0] slv;
        logic [3:0] sel;
        logic [9:0] exp_ss;
        logic [7:0] exp_cap;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v, input int id);
        int done_at = 0;
        int low_cnt = 0;
        @(negedge clk);
        cpol0 = v.cpol; cpha0 = v.cpha; lsb0 = v.lsb;
        tx0 = v.tx; sel0 = v.sel; m_slv = v.slv;
        @(negedge clk);
        check(nm(id, "idle_sclk"), 32'(sclk0), 32'(v.cpol));
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check(nm(id, "ss_sel"), 32'(ss0), 32'(v.exp_ss));
        check(nm(id, "busy"), 32'(busy0), 32'd1);
        for (int n = 1; n <= 200; n++) begin
            if (n > 1) @(negedge clk);
            if (ss0 != 10'h3FF) low_cnt++;
            if (done0) begin
                done_at = n;
                break;
            end
        end
        check(nm(id, "done_at"), 32'(done_at), 32'd73);
        check(nm(id, "ss_low"), 32'(low_cnt), 32'd72);
        check(nm(id, "rx"), 32'(rx0), 32'(v.exp_rx));
        check(nm(id, "mosi_bits"), 32'(mon_cap), 32'(v.exp_cap));
        check(nm(id, "rise"), 32'(mon_rise), 32'd8);
        check(nm(id, "toggles"), 32'(mon_tog), 32'd16);
        check(nm(id, "end_sclk"), 32'(sclk0), 32'(v.cpol));
        check(nm(id, "end_busy"), 32'(busy0), 32'd0);
        check(nm(id, "end_ss"), 32'(ss0), 32'h3FF);
    endtask

    initial begin
        logic lowv[100];
        logic donev[100];
        int   ndone, nerr, idx, run1, gap, run2, seen_done, seen_busy;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 4'd3, 10'h3F7, 8'hA5, 8'h3C};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h96, 4'd0, 10'h3FE, 8'h80, 8'h96};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h01, 8'hC1, 4'd9, 10'h1FF, 8'h80, 8'hC1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h7E, 4'd5, 10'h3DF, 8'h01, 8'h7E};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h01, 8'h2B, 4'd1, 10'h3FD, 8'h80, 8'h2B};

        repeat (3) @(negedge clk);
        check("rst_ss", 32'(ss0), 32'h3FF);
        check("rst_sclk", 32'(sclk0), 32'd0);
        check("rst_mosi", 32'(mosi0), 32'd0);
        check("rst_rx", 32'(rx0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Rejected select index
        @(negedge clk);
        sel0 = 4'd10; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("err_pulse", 32'(err0), 32'd1);
        check("err_busy", 32'(busy0), 32'd0);
        check("err_ss", 32'(ss0), 32'h3FF);
        @(negedge clk);
        check("err_clear", 32'(err0), 32'd0);
        check("err_busy2", 32'(busy0), 32'd0);

        // Asynchronous reset in cycle 30 of a mode-2 transfer
        @(negedge clk);
        cpol0 = 1'b1; cpha0 = 1'b0; lsb0 = 1'b0; tx0 = 8'hFF; sel0 = 4'd2; m_slv = 8'h00;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (29) @(negedge clk);
        check("mid_busy", 32'(busy0), 32'd1);
        check("mid_sclk", 32'(sclk0), 32'd1);
        rst0 = 1'b0;
        #1;
        check("arst_ss", 32'(ss0), 32'h3FF);
        check("arst_sclk", 32'(sclk0), 32'd0);
        check("arst_busy", 32'(busy0), 32'd0);
        check("arst_mosi", 32'(mosi0), 32'd0);
        @(negedge clk);
        rst0 = 1'b1;
        seen_done = 0;
        seen_busy = 0;
        repeat (80) begin
            @(negedge clk);
            if (done0) seen_done++;
            if (busy0) seen_busy++;
        end
        check("arst_no_done", 32'(seen_done), 32'd0);
        check("arst_no_busy", 32'(seen_busy), 32'd0);
        run_vec(vecs[0], 10);

`ifdef SPI_LOOPBACK_EN
        loopback0 = 1'b1;
        run_vec('{1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 4'd0, 10'h3FE, 8'h5A, 8'h5A}, 20);
        loopback0 = 1'b0;
`endif

        // Back-to-back with start held, DATA_W=16, CLK_DIV=1
        @(negedge clk);
        tx1 = 16'hBEEF; sel1 = 4'd7; start1 = 1'b1;
        nerr = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            lowv[n]  = (ss1 != 10'h3FF);
            donev[n] = done1;
            if (err1) nerr++;
        end
        start1 = 1'b0;
        idx = 0; run1 = 0; gap = 0; run2 = 0; ndone = 0;
        while (idx < 100 && lowv[idx]) begin run1++; idx++; end
        while (idx < 100 && !lowv[idx]) begin gap++; idx++; end
        while (idx < 100 && lowv[idx]) begin run2++; idx++; end
        for (int n = 0; n < 100; n++) if (donev[n]) ndone++;
        check("b2b_run1", 32'(run1), 32'd34);
        check("b2b_gap", 32'(gap), 32'd1);
        check("b2b_run2", 32'(run2), 32'd34);
        check("b2b_done34", 32'(donev[34]), 32'd1);
        check("b2b_done69", 32'(donev[69]), 32'd1);
        check("b2b_ndone", 32'(ndone), 32'd2);
        check("b2b_no_err", 32'(nerr), 32'd0);
        check("b2b_rx", 32'(rx1), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
